// File: rtl/fmap_buf_if.sv
// Handshake and buffer-control bundle between fmap_buf_ctrl and its
// producer, row consumer, dump consumer and the 28x7 feature-map buffer.
interface fmap_buf_if #(
    parameter int DW     = 8,
    parameter int ROW_AW = 5,
    parameter int COL_AW = 3
);
    // producer stream
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;

    // row drain to the convolution stage
    logic              row_ready;
    logic              row_valid;
    logic [ROW_AW-1:0] row_idx;
    logic              row_last;

    // single-entry dump through chip read-back
    logic              dump_ready;
    logic              dump_valid;

    // buffer controls
    logic              buf_wr_en;
    logic              buf_rd_en;
    logic              buf_chiprd_en;
    logic [ROW_AW-1:0] buf_in_row;
    logic [COL_AW-1:0] buf_in_col;
    logic [ROW_AW-1:0] buf_out_row;
    logic [COL_AW-1:0] buf_out_col;
    logic [DW-1:0]     buf_data;

    modport master (
        input  in_valid, in_data, row_ready, dump_ready,
        output in_ready, row_valid, row_idx, row_last, dump_valid,
        output buf_wr_en, buf_rd_en, buf_chiprd_en,
        output buf_in_row, buf_in_col, buf_out_row, buf_out_col, buf_data
    );

    modport slave (
        output in_valid, in_data, row_ready, dump_ready,
        input  in_ready, row_valid, row_idx, row_last, dump_valid,
        input  buf_wr_en, buf_rd_en, buf_chiprd_en,
        input  buf_in_row, buf_in_col, buf_out_row, buf_out_col, buf_data
    );
endinterface

// File: rtl/fmap_buf_ctrl.sv
// Fill / row-drain / entry-dump sequencer for the 28x7 feature-map buffer.
// Sole master of the buffer's write, row-read and chip-read strobes.
module fmap_buf_ctrl #(
    parameter int DW     = 8,
    parameter int ROWS   = 28,
    parameter int COLS   = 7,
    parameter int ROW_AW = 5,
    parameter int COL_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        drain_start,
    input  logic        dump_start,
    fmap_buf_if.master  bus,
    output logic        full,
    output logic        busy,
    output logic        done
);

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
    localparam logic [COL_AW-1:0] LAST_COL = COL_AW'(COLS - 1);
    localparam logic [ROW_AW-1:0] ROW_ZERO = {ROW_AW{1'b0}};
    localparam logic [COL_AW-1:0] COL_ZERO = {COL_AW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_FULL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ROW_AW-1:0] row_cnt_r;
    logic [ROW_AW-1:0] row_nxt_s;
    logic [COL_AW-1:0] col_cnt_r;
    logic [COL_AW-1:0] col_nxt_s;
    logic              done_r;
    logic              done_nxt_s;

    logic [ROW_AW-1:0] adv_row_s;
    logic [COL_AW-1:0] adv_col_s;
    logic              at_last_row_s;
    logic              at_last_entry_s;
    logic [DW-1:0]     data_s;

    // Row-major successor of the current (row, col) position, shared by FILL and DUMP.
    always_comb begin
        adv_row_s = row_cnt_r;
        adv_col_s = col_cnt_r;
        if (col_cnt_r == LAST_COL) begin
            adv_col_s = COL_ZERO;
            adv_row_s = row_cnt_r + ROW_AW'(1);
        end else begin
            adv_col_s = col_cnt_r + COL_AW'(1);
        end
    end

    assign at_last_row_s   = (row_cnt_r == LAST_ROW);
    assign at_last_entry_s = at_last_row_s && (col_cnt_r == LAST_COL);

    // Next-state, counter and done-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_cnt_r;
        col_nxt_s   = col_cnt_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FILL;
                    row_nxt_s   = ROW_ZERO;
                    col_nxt_s   = COL_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (bus.in_valid) begin
                    if (at_last_entry_s) begin
                        state_nxt_s = ST_FULL;
                        row_nxt_s   = ROW_ZERO;
                        col_nxt_s   = COL_ZERO;
                        done_nxt_s  = 1'b1;
                    end else begin
                        row_nxt_s = adv_row_s;
                        col_nxt_s = adv_col_s;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FULL: begin
                // drain has priority over dump, dump over a refill
                row_nxt_s = ROW_ZERO;
                col_nxt_s = COL_ZERO;
                if (drain_start) begin
                    state_nxt_s = ST_DRAIN;
                end else if (dump_start) begin
                    state_nxt_s = ST_DUMP;
                end else if (start) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (bus.row_ready) begin
                    if (at_last_row_s) begin
                        state_nxt_s = ST_FULL;
                        row_nxt_s   = ROW_ZERO;
                        col_nxt_s   = COL_ZERO;
                        done_nxt_s  = 1'b1;
                    end else begin
                        row_nxt_s = row_cnt_r + ROW_AW'(1);
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DUMP: begin
                if (bus.dump_ready) begin
                    if (at_last_entry_s) begin
                        state_nxt_s = ST_FULL;
                        row_nxt_s   = ROW_ZERO;
                        col_nxt_s   = COL_ZERO;
                        done_nxt_s  = 1'b1;
                    end else begin
                        row_nxt_s = adv_row_s;
                        col_nxt_s = adv_col_s;
                    end
                end else begin
                    state_nxt_s = ST_DUMP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                row_nxt_s   = ROW_ZERO;
                col_nxt_s   = COL_ZERO;
            end
        endcase
    end

    // State, counter and done registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            row_cnt_r <= ROW_ZERO;
            col_cnt_r <= COL_ZERO;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            row_cnt_r <= row_nxt_s;
            col_cnt_r <= col_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    // Strobes and addresses are decoded from state so at most one buffer port is active.
    always_comb begin
        bus.in_ready      = 1'b0;
        bus.buf_wr_en     = 1'b0;
        bus.buf_rd_en     = 1'b0;
        bus.buf_chiprd_en = 1'b0;
        bus.row_valid     = 1'b0;
        bus.row_last      = 1'b0;
        bus.row_idx       = ROW_ZERO;
        bus.dump_valid    = 1'b0;
        bus.buf_in_row    = ROW_ZERO;
        bus.buf_in_col    = COL_ZERO;
        bus.buf_out_row   = ROW_ZERO;
        case (state_r)
            ST_FILL: begin
                bus.in_ready   = 1'b1;
                bus.buf_wr_en  = bus.in_valid;
                bus.buf_in_row = row_cnt_r;
                bus.buf_in_col = col_cnt_r;
            end
            ST_DRAIN: begin
                bus.buf_rd_en   = 1'b1;
                bus.row_valid   = 1'b1;
                bus.row_idx     = row_cnt_r;
                bus.buf_out_row = row_cnt_r;
                bus.row_last    = at_last_row_s;
            end
            ST_DUMP: begin
                bus.buf_chiprd_en = 1'b1;
                bus.dump_valid    = 1'b1;
                bus.buf_in_row    = row_cnt_r;
                bus.buf_in_col    = col_cnt_r;
            end
            ST_IDLE, ST_FULL: begin
                bus.in_ready = 1'b0;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    assign data_s          = bus.in_data;
    assign bus.buf_data    = data_s;
    assign bus.buf_out_col = COL_ZERO;

    assign full = (state_r == ST_FULL);
    assign busy = (state_r == ST_FILL) || (state_r == ST_DRAIN) || (state_r == ST_DUMP);
    assign done = done_r;

endmodule

// File: doc/fmap_buf_ctrl.md
# fmap_buf_ctrl

Sequencing controller for the 28×7 signed feature-map buffer (8-bit entries, combinational 7-wide row read, combinational single-entry chip read-back). It takes a producer stream and writes it row-major into the buffer. It then either drains the buffer one 7-entry row per handshake to the downstream convolution stage, or dumps all 196 entries one at a time through the chip read-back port. It is the only master of the buffer's write, row-read and chip-read controls, and guarantees they are never active together.

## Interface
- DW, 8, entry width
- ROWS, 28, buffer rows
- COLS, 7, buffer columns (entries per row)
- ROW_AW, 5, row address width
- COL_AW, 3, column address width

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  begin frame fill (sampled in IDLE or FULL)
- drain_start  in  1  begin row drain (sampled in FULL)
- dump_start  in  1  begin entry dump (sampled in FULL)
- in_valid  in  1  producer data valid
- in_data  in  DW  producer data
- in_ready  out  1  controller accepts in_data
- row_ready  in  1  consumer accepts current row
- row_valid  out  1  buffer row output valid this cycle
- row_idx  out  ROW_AW  row presented
- row_last  out  1  row_idx == ROWS-1 while row_valid
- dump_ready  in  1  consumer accepts current dump entry
- dump_valid  out  1  chip read-back output valid
- buf_wr_en, buf_rd_en, buf_chiprd_en  out  1 each  buffer controls
- buf_in_row / buf_in_col  out  ROW_AW / COL_AW  buffer write / chip-read address
- buf_out_row / buf_out_col  out  ROW_AW / COL_AW  buffer row-read address; buf_out_col is constant 0
- buf_data  out  DW  buffer write data (= in_data)
- full  out  1  state == FULL
- busy  out  1  state ∈ {FILL, DRAIN, DUMP}
- done  out  1  one-cycle pulse after FILL, DRAIN or DUMP completes

## Operation
- States: IDLE, FILL, FULL, DRAIN, DUMP. Registered counters: row_cnt (0..ROWS-1) and col_cnt (0..COLS-1).
- IDLE: start -> FILL, with counters cleared. drain_start and dump_start are ignored.
- FILL:
  - in_ready = 1; buf_wr_en = in_valid.
  - buf_in_row/buf_in_col = row_cnt/col_cnt; buf_data = in_data.
  - On each in_valid & in_ready edge: col_cnt++. At col_cnt == COLS-1, col_cnt wraps to 0 and row_cnt++.
  - Accepting entry (ROWS-1, COLS-1) -> FULL, with counters cleared.
- FULL:
  - Priority is drain_start > dump_start > start.
  - drain_start -> DRAIN; dump_start -> DUMP; start -> FILL (overwrite).
  - Counters are cleared on every exit.
- DRAIN:
  - buf_rd_en = 1; row_valid = 1; row_idx = buf_out_row = row_cnt.
  - On row_valid & row_ready: row_cnt++.
  - Handshake on row_last -> FULL. Buffer contents are retained, so the frame can be re-drained.
- DUMP:
  - buf_chiprd_en = 1; dump_valid = 1; buf_in_row/buf_in_col = row_cnt/col_cnt.
  - On handshake, counters advance row-major as in FILL.
  - Handshake on (ROWS-1, COLS-1) -> FULL.
- Exclusivity: buf_wr_en and buf_rd_en are never both 1. buf_wr_en is never 1 outside FILL.
- All of buf_wr_en, buf_rd_en, buf_chiprd_en, in_ready, row_valid, dump_valid are 0 in IDLE and FULL.
- Requests arriving in a state that does not sample them are dropped, not queued.

## Timing
- Reset values: state IDLE, counters 0, all outputs 0 (buf_data follows in_data).
- Reset mid-operation returns to IDLE immediately. The buffer shares the reset, so stored data is lost.
- Handshake outputs and addresses are combinational from state and counters. in_data to buf_data is zero latency.
- A write is committed at the clk edge of the FILL handshake.
- Row data is valid in the same cycle that row_valid is high; the buffer read is combinational.
- start/drain_start/dump_start sampled at edge N put the new state in effect from cycle N+1.
- done is registered: high in the cycle after the final handshake, coinciding with the first FULL cycle.
- Throughput:
  - FILL with in_valid held high: 196 cycles.
  - DRAIN with row_ready held high: 28 cycles.
  - DUMP with dump_ready held high: 196 cycles.
- Backpressure (in_valid, row_ready or dump_ready low) holds counters and address outputs stable.

## Test plan
- Fill with in_data = k mod 128 for k = 0..195, in_valid always high. Required: full asserts on cycle 197; done pulses once; buf_in_row/col reach 27/6 at k = 195.
- Drain after fill, row_ready always high. Required: row 0 = {0,1,2,3,4,5,6}, row 27 = {61..67} (k 189..195 mod 128); row_last only at row_idx 27; returns to FULL.
- Drain with row_ready toggling 1/0. Required: row_idx advances only on handshake cycles; 28 handshakes total; buf_wr_en stays 0 throughout.
- drain_start and dump_start asserted together in FULL. Required: DRAIN entered. Then dump: entries 0..195 appear in order on chip read-back with dump_ready high.
- start pulsed in FULL, then in_valid gaps every third cycle. Required: the overwrite completes after exactly 196 accepted entries; counters hold during gaps.
- Reset asserted after 100 accepted writes. Required: IDLE, all outputs 0, full = 0; drain_start is ignored until a new fill completes.
